// File: rtl/jelly_rand_word_packer.sv
// ---------------------------------------------------------------------------
// jelly_rand_word_packer
//
// Pulls one bit per enabled cycle from a serial random bit generator, packs
// DATA_WIDTH bits MSB-first into a word, and emits a frame of frame_len
// words on a valid/ready master stream, flagging the final word with m_last.
// Filling of the next word overlaps presentation of the current one.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   cke            global clock enable (low: all state holds, m_ready ignored)
//   rand_in        random bit from the generator
//   rand_cke       generator advance; rand_in is consumed when high
//   start          frame request pulse (ignored while busy or frame_len=0)
//   frame_len      number of words in the frame, sampled with start
//   busy           frame in progress
//   m_data/m_last/m_valid/m_ready   output stream
// ---------------------------------------------------------------------------
module jelly_rand_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,

    input  logic                  rand_in,
    output logic                  rand_cke,

    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  busy,

    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_WIDTH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  sr;
    logic [CNT_W-1:0]       bit_cnt;
    logic [LEN_WIDTH-1:0]   fill_rem;

    logic                   word_full;
    logic                   out_free;
    logic                   shift_en;
    logic                   xfer_en;

    assign word_full = (bit_cnt == CNT_FULL);
    assign out_free  = !m_valid || m_ready;

    // Assembling stops once the word is complete; it resumes only after the
    // word has moved into the output register, so a stalled sink never costs
    // a random bit.
    assign shift_en  = (state == ST_RUN) && (fill_rem != '0) && !word_full;
    assign xfer_en   = (state == ST_RUN) && word_full && out_free;

    assign rand_cke  = cke && shift_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            sr       <= '0;
            bit_cnt  <= '0;
            fill_rem <= '0;
            m_data   <= '0;
            m_last   <= 1'b0;
            m_valid  <= 1'b0;
        end
        else if (cke) begin
            case (state)
                ST_IDLE: begin
                    if (start && (frame_len != '0)) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        fill_rem <= frame_len;
                        bit_cnt  <= '0;
                    end
                end

                ST_RUN: begin
                    if (shift_en) begin
                        sr      <= {sr[DATA_WIDTH-2:0], rand_in};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end

                    // Accepting the final word closes the frame. A transfer
                    // can never coincide with it: fill_rem is already 0.
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            m_last <= 1'b0;
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                        end
                    end

                    // Placed after the accept so a back-to-back reload wins
                    // over the m_valid drop.
                    if (xfer_en) begin
                        m_data   <= sr;
                        m_last   <= (fill_rem == LEN_WIDTH'(1));
                        m_valid  <= 1'b1;
                        bit_cnt  <= '0;
                        fill_rem <= fill_rem - LEN_WIDTH'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jelly_rand_word_packer.sv
module tb_jelly_rand_word_packer;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cke;
    logic          rand_in;
    logic          rand_cke;
    logic          start;
    logic [LW-1:0] frame_len;
    logic          busy;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;

    always #5 clk = ~clk;

    jelly_rand_word_packer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cke       (cke),
        .rand_in   (rand_in),
        .rand_cke  (rand_cke),
        .start     (start),
        .frame_len (frame_len),
        .busy      (busy),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    // Bit source: constant 0/1, alternating 1,0,1,... or a 16-bit LFSR
    // (x^16+x^14+x^13+x^11+1, output = MSB). Advances only on rand_cke.
    logic [15:0] lfsr;
    logic        alt;
    logic        gen_load;
    int          rin_mode;

    always_ff @(posedge clk) begin
        if (gen_load) begin
            lfsr <= 16'h0001;
            alt  <= 1'b1;
        end
        else if (rand_cke) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            alt  <= ~alt;
        end
    end

    always_comb begin
        rand_in = 1'b0;
        case (rin_mode)
            0:       rand_in = 1'b0;
            1:       rand_in = 1'b1;
            2:       rand_in = alt;
            default: rand_in = lfsr[15];
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-frame observations
    int            first_valid;
    int            busy_low;
    int            cke_cnt;
    int            late_cke;
    int            unstable;
    int            end_valid;
    logic [DW-1:0] words[$];
    bit            lasts[$];

    // Runs one frame with start in cycle 0. Inputs are driven on the falling
    // edge and outputs observed 1 time unit later. ready_mode: 0 always
    // ready, 1 random, 2 low until cycle 100. cke_mode: 0 always, 1 random.
    // xs_cyc/xs_len inject an extra start pulse that must be ignored.
    task automatic run_frame(input int len, input int rmode, input int ready_mode,
                             input int cke_mode, input int max_cyc,
                             input int xs_cyc, input int xs_len);
        bit            pheld;
        logic [DW-1:0] pd;
        logic          pl;
        first_valid = -1; busy_low = -1; cke_cnt = 0; late_cke = 0;
        unstable = 0; end_valid = -1;
        words.delete(); lasts.delete();
        pheld = 0; pd = '0; pl = 0;
        rin_mode = rmode;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            gen_load  = (c == 0);
            start     = (c == 0) || (c == xs_cyc);
            frame_len = (c == 0) ? LW'(len) : LW'(xs_len);
            cke       = (cke_mode == 0 || c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            case (ready_mode)
                0:       m_ready = 1'b1;
                2:       m_ready = (c >= 100);
                default: m_ready = $urandom_range(0, 1) != 0;
            endcase
            #1;
            if (pheld && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) unstable++;
            pheld = m_valid && !(m_ready && cke);
            pd = m_data;
            pl = m_last;
            if (rand_cke) begin
                cke_cnt++;
                if (ready_mode == 2 && c >= 66 && c < 100) late_cke++;
            end
            if (m_valid && first_valid < 0) first_valid = c;
            if (cke && m_valid && m_ready) begin
                words.push_back(m_data);
                lasts.push_back(m_last);
            end
            if (c > 0 && !busy) begin
                busy_low  = c;
                end_valid = int'(m_valid) + int'(m_last);
                break;
            end
        end
        start = 1'b0; gen_load = 1'b0; cke = 1'b1;
    endtask

    task automatic check_const_words(input string tag, input int len, input logic [DW-1:0] w);
        chk({tag, " word count"}, 64'(words.size()), 64'(len));
        for (int i = 0; i < words.size() && i < len; i++) begin
            chk($sformatf("%s word%0d", tag, i), 64'(words[i]), 64'(w));
            chk($sformatf("%s last%0d", tag, i), 64'(lasts[i]), 64'(i == len - 1));
        end
        chk({tag, " end valid/last"}, 64'(end_valid), 64'd0);
        chk({tag, " stable while held"}, 64'(unstable), 64'd0);
    endtask

    typedef struct {
        int            rmode;
        int            len;
        int            ready_mode;
        logic [DW-1:0] word;
        int            fv;
        int            bl;
        int            ckc;
    } vec_t;

    vec_t vecs[5];
    bit   s[$];
    logic [DW-1:0] ew;
    int   cnt;

    initial begin
        // rmode len ready word          first_valid busy_low rand_cke
        vecs[0] = '{1, 3, 0, 32'hFFFFFFFF, 34, 101, 96};
        vecs[1] = '{2, 1, 0, 32'hAAAAAAAA, 34,  35, 32};
        vecs[2] = '{0, 2, 0, 32'h00000000, 34,  68, 64};
        vecs[3] = '{1, 1, 0, 32'hFFFFFFFF, 34,  35, 32};
        vecs[4] = '{1, 2, 2, 32'hFFFFFFFF, 34, 102, 64};

        reset = 1'b1; cke = 1'b1; start = 1'b0; frame_len = '0;
        m_ready = 1'b0; gen_load = 1'b0; rin_mode = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset m_valid",  64'(m_valid),  64'd0);
        chk("reset m_last",   64'(m_last),   64'd0);
        chk("reset m_data",   64'(m_data),   64'd0);
        chk("reset busy",     64'(busy),     64'd0);
        chk("reset rand_cke", 64'(rand_cke), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            run_frame(vecs[i].len, vecs[i].rmode, vecs[i].ready_mode, 0, 600, -1, 0);
            chk({t, " first valid cycle"}, 64'(first_valid), 64'(vecs[i].fv));
            chk({t, " busy low cycle"},    64'(busy_low),    64'(vecs[i].bl));
            chk({t, " rand_cke count"},    64'(cke_cnt),     64'(vecs[i].ckc));
            chk({t, " rand_cke in stall"}, 64'(late_cke),    64'd0);
            check_const_words(t, vecs[i].len, vecs[i].word);
        end

        // start with frame_len=0 is ignored
        @(negedge clk);
        start = 1'b1; frame_len = '0; cke = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin @(negedge clk); start = 1'b0; end
            #1;
            if (rand_cke || busy) cnt++;
        end
        start = 1'b0;
        chk("len0 busy/rand_cke", 64'(cnt), 64'd0);

        // start with len 5 mid-frame does not change the length
        run_frame(3, 1, 0, 0, 600, 40, 5);
        chk("midstart busy low", 64'(busy_low), 64'd101);
        check_const_words("midstart", 3, 32'hFFFFFFFF);

        // start in the cycle the last word is accepted is ignored
        run_frame(1, 1, 0, 0, 200, 34, 2);
        chk("laststart busy low", 64'(busy_low), 64'd35);
        @(negedge clk);
        #1;
        chk("laststart stays idle", 64'({busy, rand_cke}), 64'd0);

        // LFSR stream, random ready and cke gaps: words are consecutive
        // 32-bit chunks of the LFSR output sequence, MSB first.
        s.delete();
        for (int k = 0; k < 16; k++) s.push_back(k == 15);
        for (int t = 0; t < 4 * DW; t++) s.push_back(s[t] ^ s[t+2] ^ s[t+3] ^ s[t+5]);
        run_frame(4, 3, 1, 1, 4000, -1, 0);
        chk("lfsr word count", 64'(words.size()), 64'd4);
        chk("lfsr rand_cke count", 64'(cke_cnt), 64'd128);
        chk("lfsr stable while held", 64'(unstable), 64'd0);
        chk("lfsr busy dropped", 64'(busy_low > 0), 64'd1);
        for (int k = 0; k < 4 && k < words.size(); k++) begin
            for (int b = 0; b < DW; b++) ew[DW-1-b] = s[k*DW + b];
            chk($sformatf("lfsr word%0d", k), 64'(words[k]), 64'(ew));
            chk($sformatf("lfsr last%0d", k), 64'(lasts[k]), 64'(k == 3));
        end

        // reset in cycle 50 of a 4-word frame
        rin_mode = 1; m_ready = 1'b1;
        for (int c = 0; c <= 51; c++) begin
            @(negedge clk);
            start = (c == 0); frame_len = 16'd4; reset = (c == 50); cke = 1'b1;
            #1;
            if (c == 1) chk("pre-reset busy", 64'(busy), 64'd1);
        end
        chk("midreset m_valid",  64'(m_valid),  64'd0);
        chk("midreset busy",     64'(busy),     64'd0);
        chk("midreset rand_cke", 64'(rand_cke), 64'd0);
        chk("midreset m_data",   64'(m_data),   64'd0);
        reset = 1'b0; start = 1'b0;
        run_frame(4, 1, 0, 0, 600, -1, 0);
        chk("postreset busy low", 64'(busy_low), 64'd134);
        chk("postreset rand_cke count", 64'(cke_cnt), 64'd128);
        check_const_words("postreset", 4, 32'hFFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jelly_rand_word_packer.md
# jelly_rand_word_packer

Downstream consumer of the 16-bit LFSR random bit generator. It pulls one random bit per enabled cycle by driving the generator's `cke` through `rand_cke`. It assembles `DATA_WIDTH` bits into a word and issues a frame of `frame_len` words on a valid/ready master stream with `m_last` on the final word. It is used as a pseudo-random traffic source for stream datapath testing and BIST.

## Interface
Parameters:
- `DATA_WIDTH`, 32: output word width, ≥ 2.
- `LEN_WIDTH`, 16: width of the frame length (in words).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `cke`  in  1  global clock enable. When low, all state holds, `rand_cke`=0 and `m_ready` is ignored.
- `rand_in`  in  1  random bit from the generator's `out`.
- `rand_cke`  out  1  generator advance. `rand_in` is consumed in every cycle this is high.
- `start`  in  1  frame request pulse.
- `frame_len`  in  LEN_WIDTH  words in the frame, sampled with `start`.
- `busy`  out  1  frame in progress.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  final word of the frame.
- `m_valid`  out  1  output valid.
- `m_ready`  in  1  output ready.

## Operation
- Storage:
  - shift register `sr` of `DATA_WIDTH` bits;
  - bit counter `bit_cnt` (0..DATA_WIDTH);
  - fill counter `fill_rem` (words still to assemble);
  - output register holding `m_data`/`m_last`/`m_valid`;
  - `busy` flag.
- States:
  - IDLE (`busy`=0);
  - RUN (`busy`=1, filling and/or draining).
- IDLE→RUN: when `cke`, `start`=1 and `frame_len`≠0. Latch `fill_rem`=`frame_len` and clear `bit_cnt`.
- `start` with `frame_len`=0, and `start` while `busy`: ignored.
- Shift: in RUN with `fill_rem`≠0 and `bit_cnt`<DATA_WIDTH:
  - `rand_cke` = `cke`;
  - on each enabled edge: `sr` ← {`sr`[DATA_WIDTH-2:0], `rand_in`}, `bit_cnt`+1.
  - The first bit sampled ends in the MSB.
- `rand_cke` is combinational from registered state and `cke`. It is 0 whenever not shifting.
- Transfer: when `bit_cnt`=DATA_WIDTH and the output register is free (`m_valid`=0 or `m_ready`=1), on an enabled edge:
  - `m_data` ← `sr`;
  - `m_last` ← (`fill_rem`=1);
  - `m_valid` ← 1;
  - `bit_cnt` ← 0;
  - `fill_rem` − 1.
- No shift occurs in a transfer cycle.
- Stall: if `bit_cnt`=DATA_WIDTH and the output is held (`m_valid`=1, `m_ready`=0), `rand_cke`=0 and `sr` holds. No random bits are lost or skipped.
- Handshake: a word is accepted on an enabled edge with `m_valid`&&`m_ready`. `m_valid` drops unless a transfer loads a new word in the same cycle.
- `m_data`/`m_last` are stable while `m_valid`=1 and `m_ready`=0.
- RUN→IDLE: on the edge accepting the word with `m_last`=1. `busy`, `m_valid` and `m_last` are 0 on the next cycle.
- Exactly `frame_len`×DATA_WIDTH `rand_cke` cycles occur per frame.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `rand_cke`=0, `sr`=0, counters 0, state IDLE.
- Reset mid-frame discards all partial and pending words. The next cycle shows the reset values. The generator is reseeded independently.
- Latency (`cke`=1, no backpressure), with `start` sampled at the end of cycle 0:
  - `busy`=1 from cycle 1;
  - `rand_cke`=1 in cycles 1..DATA_WIDTH;
  - transfer in cycle DATA_WIDTH+1;
  - `m_valid`=1 from cycle DATA_WIDTH+2.
- Throughput: one word per DATA_WIDTH+1 cycles. Filling of word k+1 overlaps presentation of word k.
- `cke`=0 freezes every register; outputs keep their values.
- Boundaries:
  - `frame_len`=1: the single word has `m_last`=1.
  - `frame_len`=2^LEN_WIDTH−1: `fill_rem` counts down to 0 without wrap.
  - `start` in the cycle the last word is accepted is ignored (`busy` still 1).

## Test plan
- Constant ones: `rand_in`=1, `frame_len`=3, `m_ready`=1 -> three words 0xFFFFFFFF; `m_last` on the third only; `m_valid` first high at cycle 34; `busy` low at cycle 101.
- Alternating bits: bench drives `rand_in`=1,0,1,0… on `rand_cke` cycles, `frame_len`=1 -> `m_data`=0xAAAAAAAA, `m_last`=1; exactly 32 `rand_cke` cycles in total.
- Backpressure: `frame_len`=2, `m_ready`=0 until cycle 100 -> `rand_cke`=0 from cycle 66 (second word assembled); word 1 is held stable; both words are delivered in order after `m_ready`=1; total `rand_cke` cycles = 64.
- With the real generator (seed 16'h0001) against a reference model of the LFSR bit stream, `frame_len`=4, random `m_ready` and random `cke` gaps -> words match the model's bit sequence MSB-first; no bit lost or duplicated.
- Ignored starts: `start` with `frame_len`=0 -> `busy` stays 0 and no `rand_cke`; `start` with `frame_len`=5 mid-frame -> frame length unchanged.
- Reset mid-frame: reset asserted at cycle 50 of a 4-word frame -> next cycle `m_valid`=0, `busy`=0, `rand_cke`=0; a new `start` yields a full-length frame.
